reg_file: RTL

- Architectural register file with rename tags for the Tomasulo RISC-V core.
- Sits at the receiving end of the reorder buffer's commit interface (rf_out_en / rf_rob_idx_out / rf_dest_out / rf_val_out).
- Accepts renames from the decoder and serves two combinational operand lookups, each returning a value or the ROB tag of the pending producer.
- Clears all pending tags on the ROB roll_back pulse.

---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/reg_file_if.sv | 37 +++
 rtl/reg_file_lookup.sv | 43 ++++
 rtl/reg_file.sv | 68 ++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizes and types for the architectural register file with rename tags.
package reg_file_pkg;

  localparam int unsigned REG_NUM      = 32;
  localparam int unsigned REG_IDX_SIZE = 5;
  localparam int unsigned ROB_IDX_SIZE = 4;
  localparam int unsigned DATA_SIZE    = 32;

  typedef logic [REG_IDX_SIZE-1:0] reg_idx_t;
  typedef logic [ROB_IDX_SIZE-1:0] rob_idx_t;
  typedef logic [DATA_SIZE-1:0]    data_t;

  typedef struct packed {
    data_t    val;
    logic     busy;
    rob_idx_t tag;
  } reg_entry_t;

  typedef struct packed {
    logic     en;
    rob_idx_t idx;
    reg_idx_t dest;
    data_t    val;
  } commit_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FWD,
    SRC_TAG,
    SRC_REG
  } lookup_src_e;

endpackage

// File: rtl/reg_file_if.sv
// Commit, rename and operand-lookup signals between ROB/decoder and the register file.
interface reg_file_if;
  import reg_file_pkg::*;

  logic     rob_in_en;
  rob_idx_t rob_idx_in;
  reg_idx_t rob_dest_in;
  data_t    rob_val_in;

  logic     de_rename_en;
  reg_idx_t de_rename_reg;
  rob_idx_t de_rename_idx;

  reg_idx_t rs1_idx;
  reg_idx_t rs2_idx;
  logic     rs1_busy;
  logic     rs2_busy;
  rob_idx_t rs1_tag;
  rob_idx_t rs2_tag;
  data_t    rs1_val;
  data_t    rs2_val;

  modport slave (
    input  rob_in_en, rob_idx_in, rob_dest_in, rob_val_in,
    input  de_rename_en, de_rename_reg, de_rename_idx,
    input  rs1_idx, rs2_idx,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
  );

  modport master (
    output rob_in_en, rob_idx_in, rob_dest_in, rob_val_in,
    output de_rename_en, de_rename_reg, de_rename_idx,
    output rs1_idx, rs2_idx,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
  );

endinterface

// File: rtl/reg_file_lookup.sv
// Combinational operand read: zero register, commit forwarding, pending tag or stored value.
module reg_file_lookup
  import reg_file_pkg::*;
(
  input  reg_idx_t   idx_i,
  input  reg_entry_t entry_i,
  input  commit_t    commit_i,
  output logic       busy_o,
  output rob_idx_t   tag_o,
  output data_t      val_o
);

  lookup_src_e src;

  // Forward only when the committing tag is exactly the producer this register waits on.
  always_comb begin
    src = SRC_REG;
    if (idx_i == '0) begin
      src = SRC_ZERO;
    end else if (entry_i.busy && commit_i.en && commit_i.dest == idx_i &&
                 commit_i.idx == entry_i.tag) begin
      src = SRC_FWD;
    end else if (entry_i.busy) begin
      src = SRC_TAG;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    tag_o  = '0;
    val_o  = '0;
    case (src)
      SRC_ZERO: ;
      SRC_FWD:  val_o = commit_i.val;
      SRC_TAG: begin
        busy_o = 1'b1;
        tag_o  = entry_i.tag;
      end
      SRC_REG:  val_o = entry_i.val;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, ROB commit and roll-back flush.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst_in,
  input logic       rdy_in,
  input logic       roll_back,
  reg_file_if.slave bus
);

  reg_entry_t rf_q [REG_NUM];
  reg_entry_t rf_d [REG_NUM];
  commit_t    commit;

  always_comb begin
    commit.en   = bus.rob_in_en;
    commit.idx  = bus.rob_idx_in;
    commit.dest = bus.rob_dest_in;
    commit.val  = bus.rob_val_in;
  end

  // Commit first, then flush or rename, so a same-cycle rename overrides the commit's busy clear.
  always_comb begin
    rf_d = rf_q;
    if (commit.en && commit.dest != '0) begin
      rf_d[commit.dest].val = commit.val;
      if (rf_q[commit.dest].busy && rf_q[commit.dest].tag == commit.idx) begin
        rf_d[commit.dest].busy = 1'b0;
      end
    end
    if (roll_back) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        rf_d[i].busy = 1'b0;
      end
    end else if (bus.de_rename_en && bus.de_rename_reg != '0) begin
      rf_d[bus.de_rename_reg].busy = 1'b1;
      rf_d[bus.de_rename_reg].tag  = bus.de_rename_idx;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rf_q <= '{default: '0};
    end else if (rdy_in) begin
      rf_q <= rf_d;
    end
  end

  reg_file_lookup u_rs1 (
    .idx_i    (bus.rs1_idx),
    .entry_i  (rf_q[bus.rs1_idx]),
    .commit_i (commit),
    .busy_o   (bus.rs1_busy),
    .tag_o    (bus.rs1_tag),
    .val_o    (bus.rs1_val)
  );

  reg_file_lookup u_rs2 (
    .idx_i    (bus.rs2_idx),
    .entry_i  (rf_q[bus.rs2_idx]),
    .commit_i (commit),
    .busy_o   (bus.rs2_busy),
    .tag_o    (bus.rs2_tag),
    .val_o    (bus.rs2_val)
  );

endmodule
